// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and the MEM stage state type
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;
endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB result register
// A load captures a valid result; any other cycle leaves a bubble (payload held).
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_W  = pipe_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_reg,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_we,
  output logic [REG_W-1:0]  o_reg,
  output logic [DATA_W-1:0] o_data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_we    <= 1'b0;
      o_reg   <= '0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_we    <= i_we;
      o_reg   <= i_reg;
      o_data  <= i_data;
    end else begin
      o_valid <= 1'b0;
      o_we    <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory req/ack access into MEM/WB
// Non-memory ops pass in one cycle; loads/stores stall upstream until ack or timeout.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W      = pipe_pkg::DATA_W,
  parameter int REG_W       = pipe_pkg::REG_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              DataMemWE,
  input  logic              WriteDataSrc,
  input  logic              RegWE,
  input  logic [DATA_W-1:0] ALURes,
  input  logic [DATA_W-1:0] Reg2DataOut,
  input  logic [REG_W-1:0]  RegisterFile,
  output logic              pauseOut,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_misalign,
  output logic              err_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_e        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_load, r_regwe;
  logic [REG_W-1:0]  r_reg;

  logic              w_memop, w_aligned, w_tmo_hit;
  logic              w_accept, w_done, w_err_mis, w_err_tmo;
  logic              w_wb_load, w_wb_we;
  logic [DATA_W-1:0] w_wb_data;
  logic [REG_W-1:0]  w_wb_reg;

  assign w_memop   = in_valid & (DataMemWE | WriteDataSrc);
  assign w_aligned = (ALURes[1:0] == 2'b00);
  // Ack takes priority: the limit only fires on a cycle without ack.
  assign w_tmo_hit = (r_state == BUSY) & ~mem_ack & (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_err_mis    = 1'b0;
    w_err_tmo    = 1'b0;
    w_wb_load    = 1'b0;
    w_wb_we      = 1'b0;
    w_wb_data    = ALURes;
    w_wb_reg     = RegisterFile;
    pauseOut     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && !w_memop) begin
          w_wb_load = 1'b1;
          w_wb_we   = RegWE;
        end else if (w_memop && !w_aligned) begin
          w_err_mis = 1'b1;
        end else if (w_memop) begin
          w_accept     = 1'b1;
          pauseOut     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        w_wb_reg = r_reg;
        if (mem_ack) begin
          w_done       = 1'b1;
          w_wb_load    = 1'b1;
          w_wb_we      = r_is_load & r_regwe;
          w_wb_data    = r_is_load ? mem_rdata : '0;
          w_next_state = IDLE;
        end else if (w_tmo_hit) begin
          w_done       = 1'b1;
          w_err_tmo    = 1'b1;
          w_next_state = IDLE;
        end else begin
          pauseOut = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      r_cnt        <= '0;
      r_is_load    <= 1'b0;
      r_regwe      <= 1'b0;
      r_reg        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= w_err_mis;
      err_timeout  <= w_err_tmo;
      if (w_accept) begin
        mem_req   <= 1'b1;
        mem_we    <= DataMemWE;
        mem_addr  <= {ALURes[DATA_W-1:2], 2'b00};
        mem_wdata <= Reg2DataOut;
        r_is_load <= ~DataMemWE;
        r_regwe   <= RegWE;
        r_reg     <= RegisterFile;
        r_cnt     <= '0;
      end else if (w_done) begin
        mem_req <= 1'b0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_wb_load),
    .i_we    (w_wb_we),
    .i_reg   (w_wb_reg),
    .i_data  (w_wb_data),
    .o_valid (wb_valid),
    .o_we    (wb_we),
    .o_reg   (wb_reg),
    .o_data  (wb_data)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, DataMemWE, WriteDataSrc, RegWE;
  logic [31:0] ALURes, Reg2DataOut;
  logic [4:0]  RegisterFile;
  logic        pauseOut, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_we, err_misalign, err_timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .DataMemWE(DataMemWE),
    .WriteDataSrc(WriteDataSrc), .RegWE(RegWE), .ALURes(ALURes),
    .Reg2DataOut(Reg2DataOut), .RegisterFile(RegisterFile), .pauseOut(pauseOut),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_reg(wb_reg), .wb_data(wb_data), .err_misalign(err_misalign),
    .err_timeout(err_timeout)
  );

  // kind: 0 writeback, 1 misalign error, 2 timeout error
  typedef struct {
    int          kind;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
    bit          chk_data;
    int          due;
  } exp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          exp_pause = 1'b0;
  logic        prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_0F0F);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    req_t r;
    int   n_out;
    int   kind_act;
    if (mon_en) begin
      check("pauseOut", 32'(pauseOut), 32'(exp_pause));
      n_out = int'(wb_valid) + int'(err_misalign) + int'(err_timeout);
      if (n_out > 1) check("exclusive_outputs", 32'(n_out), 32'd1);
      if (n_out != 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: wb_valid=%b mis=%b tmo=%b expected none (cycle %0d)",
                   wb_valid, err_misalign, err_timeout, cyc);
        end else begin
          e = exp_q.pop_front();
          kind_act = err_timeout ? 2 : (err_misalign ? 1 : 0);
          check("output_kind", 32'(kind_act), 32'(e.kind));
          check("output_cycle", 32'(cyc), 32'(e.due));
          if (e.kind == 0) begin
            check("wb_we", 32'(wb_we), 32'(e.we));
            if (e.we) check("wb_reg", 32'(wb_reg), 32'(e.rg));
            if (e.chk_data) check("wb_data", wb_data, e.data);
          end
        end
      end
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_mem_req: addr=%h expected no request", mem_addr);
        end else begin
          r = req_q.pop_front();
          check("mem_addr", mem_addr, r.addr);
          check("mem_we", 32'(mem_we), 32'(r.we));
          if (r.we) check("mem_wdata", mem_wdata, r.wdata);
        end
      end
    end
    prev_req = mem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 bubble, 1 ALU op, 2 load, 3 store; d = non-ack cycles before ack
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] wd,
                       input logic rwe, input logic [4:0] rg, input int d);
    exp_t e;
    req_t r;
    int   kend;
    in_valid     = (kind != 0);
    DataMemWE    = (kind == 3);
    WriteDataSrc = (kind == 2) ? 1'b1 : ((kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
    ALURes       = a;
    Reg2DataOut  = wd;
    RegWE        = rwe;
    RegisterFile = rg;
    mem_ack      = 1'b0;
    e.we = rwe; e.rg = rg; e.data = a; e.chk_data = 1'b1;
    if (kind <= 1) begin
      exp_pause = 1'b0;
      if (kind == 1) begin
        e.kind = 0; e.due = cyc + 1;
        exp_q.push_back(e);
      end
      step();
    end else if (a[1:0] != 2'b00) begin
      exp_pause = 1'b0;
      e.kind = 1; e.due = cyc + 1;
      exp_q.push_back(e);
      step();
    end else begin
      r.we = (kind == 3); r.addr = a; r.wdata = wd;
      req_q.push_back(r);
      kend = (d < TMO) ? d : TMO - 1;
      e.due = cyc + 2 + kend;
      if (d >= TMO) begin
        e.kind = 2;
      end else begin
        e.kind = 0;
        e.we = (kind == 2) ? rwe : 1'b0;
        e.data = rd_mem(a);
        e.chk_data = (kind == 2);
      end
      exp_q.push_back(e);
      exp_pause = 1'b1;
      step();
      for (int k = 0; k < TMO; k++) begin
        mem_ack   = (k == d);
        mem_rdata = (k == d) ? rd_mem(a) : $urandom;
        exp_pause = (k != d) && !(d >= TMO && k == TMO - 1);
        step();
        if (k == d) break;
      end
      if (kind == 3 && d < TMO) mem_model[a] = wd;
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    int          kind;
    logic [31:0] a;
    rst = 1'b1;
    in_valid = 0; DataMemWE = 0; WriteDataSrc = 0; RegWE = 0;
    ALURes = '0; Reg2DataOut = '0; RegisterFile = '0;
    mem_ack = 0; mem_rdata = '0;
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_errors", {30'd0, err_misalign, err_timeout}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    issue(1, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 0);
    mem_model[32'h100] = 32'hDEAD_BEEF;
    issue(2, 32'h0000_0100, 32'h0, 1'b1, 5'd7, 3);
    issue(3, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 5'd9, 0);
    issue(2, 32'h0000_0200, 32'h0, 1'b1, 5'd10, 1);
    issue(2, 32'h0000_0103, 32'h0, 1'b1, 5'd3, 0);
    issue(3, 32'h0000_0202, 32'h1111_2222, 1'b0, 5'd3, 0);
    issue(2, 32'h0000_0108, 32'h0, 1'b1, 5'd4, 5);
    issue(3, 32'h0000_010C, 32'h3333_4444, 1'b1, 5'd6, TMO);
    issue(2, 32'h0000_010C, 32'h0, 1'b1, 5'd8, TMO - 1);
    issue(0, 32'h0, 32'h0, 1'b0, 5'd0, 0);
    issue(1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd31, 0);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 3);
      a = 32'h300 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if (kind == 1) a = $urandom;
      else if (kind >= 2 && $urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(kind, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom_range(0, TMO + 1));
    end
    issue(0, 32'h0, 32'h0, 1'b0, 5'd0, 0);

    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h104; r.wdata = '0;
      req_q.push_back(r);
      in_valid = 1; DataMemWE = 0; WriteDataSrc = 1; RegWE = 1;
      ALURes = 32'h104; RegisterFile = 5'd12; mem_ack = 0;
      exp_pause = 1'b1;
      step();
      step();
      mon_en = 1'b0;
      rst = 1'b1;
      in_valid = 0;
      step();
      check("midrst_mem_req", 32'(mem_req), 32'd0);
      check("midrst_pauseOut", 32'(pauseOut), 32'd0);
      check("midrst_wb_valid", 32'(wb_valid), 32'd0);
      check("midrst_errors", {30'd0, err_misalign, err_timeout}, 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      rst = 1'b0;
      exp_pause = 1'b0;
      mon_en = 1'b1;
      repeat (TMO + 2) step();
    end

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
